// File: rtl/reg_write_arb_if.sv
// Request/grant/data bundle between the requesters and the shared-register write arbiter.
interface reg_write_arb_if #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic                  wr_en;
    logic [WIDTH-1:0]      q;
    logic                  busy;

    modport master (output req, wdata, input gnt, wr_en, q, busy);
    modport slave  (input req, wdata, output gnt, wr_en, q, busy);
endinterface

// File: rtl/reg_write_arb.sv
// Round-robin arbiter serialising NREQ writers onto one shared register (IDLE/GRANT/WRITE/RELEASE).
// Optional synchronous set input s is built in when DFF_SET_EN is defined.
module reg_write_arb #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic r,
`ifdef DFF_SET_EN
    input  logic s,
`endif
    reg_write_arb_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, WRITE, RELEASE} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [IW-1:0]   nxt;
    logic            found;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] sel;

    // Search begins one past the last winner so a freshly served requester goes last.
    always_comb begin
        nxt   = ptr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && bus.req[IW'((int'(ptr) + k) % NREQ)]) begin
                found = 1'b1;
                nxt   = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) sel = bus.wdata[i*WIDTH +: WIDTH];
        end
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (r) begin
            state     <= IDLE;
            bus.gnt   <= '0;
            bus.wr_en <= 1'b0;
            bus.q     <= '0;
            hold      <= '0;
            win       <= '0;
            ptr       <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.gnt <= NREQ'(1) << nxt;
                        win     <= nxt;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    hold      <= sel;
                    bus.wr_en <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    bus.q     <= hold;
                    bus.wr_en <= 1'b0;
                    bus.gnt   <= '0;
                    ptr       <= win;
                    state     <= RELEASE;
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef DFF_SET_EN
            // Set wins over a same-edge write; the sequencer itself is unaffected.
            if (s) bus.q <= '1;
`endif
        end
    end
endmodule

// File: tb/tb_reg_write_arb.sv
// Scoreboard bench for reg_write_arb: expected grant/data pushed at stimulus, checked on each wr_en pulse.
module tb_reg_write_arb;
    localparam int NREQ  = 3;
    localparam int WIDTH = 8;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic r   = 1'b1;
`ifdef DFF_SET_EN
    logic s   = 1'b0;
`endif
    int   n_tests = 0;
    int   n_fail  = 0;
    int   nwr     = 0;
    int   nwr_exp = 0;
    logic pend    = 1'b0;
    exp_t cur;
    exp_t sbq[$];

    reg_write_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    reg_write_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk),
        .r  (r),
`ifdef DFF_SET_EN
        .s  (s),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] d);
        exp_t e;
        e.gnt  = g;
        e.data = d;
        sbq.push_back(e);
        nwr_exp++;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && (bus.busy || sbq.size() != 0 || pend); i++) step(1);
        chk("idle_reached", {30'd0, bus.busy, (sbq.size() != 0)}, 32'd0);
    endtask

    // Monitor: grant checked in the WRITE cycle, q checked one cycle later.
    always @(negedge clk) begin
        if (pend) begin
            chk("q_after_write", 32'(bus.q), 32'(cur.data));
            pend = 1'b0;
        end
        if (bus.wr_en) begin
            nwr++;
            chk("sb_nonempty_on_wr", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                cur = sbq.pop_front();
                chk("gnt_in_write", 32'(bus.gnt), 32'(cur.gnt));
                pend = 1'b1;
            end
        end
    end

    initial begin
        bus.req   = '0;
        bus.wdata = '0;
        step(2);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_q", 32'(bus.q), 32'd0);
        r = 1'b0;
        step(1);

        // Single request with latency checks
        bus.req = 3'b010;
        bus.wdata[15:8] = 8'hA5;
        push(3'b010, 8'hA5);
        step(1);
        chk("lat_gnt_k", 32'(bus.gnt), 32'h2);
        chk("lat_busy_k", 32'(bus.busy), 32'd1);
        chk("lat_wr_k", 32'(bus.wr_en), 32'd0);
        bus.req = '0;
        step(1);
        chk("lat_wr_k1", 32'(bus.wr_en), 32'd1);
        chk("lat_gnt_k1", 32'(bus.gnt), 32'h2);
        step(1);
        chk("lat_q_k2", 32'(bus.q), 32'hA5);
        chk("lat_gnt_k2", 32'(bus.gnt), 32'd0);
        chk("lat_wr_k2", 32'(bus.wr_en), 32'd0);
        chk("lat_busy_k2", 32'(bus.busy), 32'd1);
        step(1);
        chk("lat_busy_k3", 32'(bus.busy), 32'd0);
        wait_idle();

        // Fairness from reset: all pending, grants rotate 0,1,2,0
        r = 1'b1;
        step(1);
        r = 1'b0;
        bus.req   = 3'b111;
        bus.wdata = {8'h33, 8'h22, 8'h11};
        push(3'b001, 8'h11);
        push(3'b010, 8'h22);
        push(3'b100, 8'h33);
        push(3'b001, 8'h11);
        step(13);
        bus.req = '0;
        wait_idle();

        // Reset during WRITE aborts the write
        bus.req = 3'b010;
        bus.wdata[15:8] = 8'h5A;
        push(3'b010, 8'h00);
        step(1);
        bus.req = '0;
        step(1);
        r = 1'b1;
        step(1);
        chk("mrst_q", 32'(bus.q), 32'd0);
        chk("mrst_gnt", 32'(bus.gnt), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_wr", 32'(bus.wr_en), 32'd0);
        r = 1'b0;
        step(3);
        bus.req = 3'b111;
        bus.wdata[7:0] = 8'h77;
        push(3'b001, 8'h77);
        step(1);
        chk("mrst_first_win", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        wait_idle();

        // One-cycle request pulse still completes
        bus.req = 3'b100;
        bus.wdata[23:16] = 8'hC3;
        push(3'b100, 8'hC3);
        step(1);
        bus.req = '0;
        wait_idle();
        chk("drop_q", 32'(bus.q), 32'hC3);

`ifdef DFF_SET_EN
        bus.req = 3'b001;
        bus.wdata[7:0] = 8'h0F;
        push(3'b001, 8'hFF);
        step(1);
        bus.req = '0;
        step(1);
        s = 1'b1;
        step(1);
        s = 1'b0;
        chk("set_q", 32'(bus.q), 32'hFF);
        wait_idle();
        r = 1'b1;
        s = 1'b1;
        step(1);
        chk("rst_over_set", 32'(bus.q), 32'd0);
        r = 1'b0;
        s = 1'b0;
        step(1);
`endif

        chk("wr_count", 32'(nwr), 32'(nwr_exp));
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
